// File: rtl/uart_fifo_core.sv
// uart_fifo_core
//   Full-duplex UART with a TX FIFO in front of the transmitter and an RX FIFO
//   behind the receiver. Frame: start, DATA_WIDTH data bits LSB first,
//   optional parity, one or two stop bits. Each line bit lasts
//   DIV = IN_CLK / BAUD_RATE clock cycles.
//
// Ports
//   pi_clk, pi_rst            clock, synchronous active-high reset
//   pi_stop_bits              0: one stop bit, 1: two (TX only; RX checks one)
//   pi_parity_mode            00/11 none, 01 even, 10 odd
//   pi_t_data/pi_t_valid/po_t_ready   TX FIFO write side
//   po_ut_data                serial TX line (idle high, registered)
//   pi_ur_data                serial RX line (asynchronous)
//   po_r_data/po_r_valid/pi_r_ready   RX FIFO read side (first-word-fall-through)
//   po_tx_count, po_rx_count  FIFO occupancies 0..FIFO_DEPTH
//   po_tx_busy                transmitter not idle
//   po_parity_err, po_frame_err, po_overrun_err   sticky flags, pi_err_clr clears
//   po_tx_state, po_rx_state  FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and data is only meaningful while
// valid is high.

module uart_fifo_core #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_CLK     = 10000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          pi_clk,
   input  logic                          pi_rst,
   input  logic                          pi_stop_bits,
   input  logic [1:0]                    pi_parity_mode,
   input  logic [DATA_WIDTH-1:0]         pi_t_data,
   input  logic                          pi_t_valid,
   output logic                          po_t_ready,
   output logic                          po_ut_data,
   input  logic                          pi_ur_data,
   output logic [DATA_WIDTH-1:0]         po_r_data,
   output logic                          po_r_valid,
   input  logic                          pi_r_ready,
   output logic [$clog2(FIFO_DEPTH):0]   po_tx_count,
   output logic [$clog2(FIFO_DEPTH):0]   po_rx_count,
   output logic                          po_tx_busy,
   output logic                          po_parity_err,
   output logic                          po_frame_err,
   output logic                          po_overrun_err,
   input  logic                          pi_err_clr,
   output logic [2:0]                    po_tx_state,
   output logic [2:0]                    po_rx_state
);

   localparam int DIV   = IN_CLK / BAUD_RATE;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [BW-1:0]    BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- TX FIFO
   logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
   logic [AW-1:0]         tx_wr, tx_rd;
   logic [CW-1:0]         tx_cnt;
   logic                  tx_push, tx_pop;
   logic [DATA_WIDTH-1:0] tx_head;

   assign po_t_ready  = (tx_cnt != DEPTH_C);
   // Fullness is judged on the registered count, so a pop in the same cycle
   // does not make room for a push.
   assign tx_push     = pi_t_valid && po_t_ready;
   assign tx_head     = tx_mem[tx_rd];
   assign po_tx_count = tx_cnt;

   always_ff @(posedge pi_clk) begin
      if (tx_push) tx_mem[tx_wr] <= pi_t_data;
   end

   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + AW'(1);
         if (tx_pop)  tx_rd <= tx_rd + AW'(1);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
   end

   // ---------------------------------------------------------------- TX FSM
   tx_state_t             tx_state;
   logic [CNT_W-1:0]      tx_bcnt;
   logic [BW-1:0]         tx_bit;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  tx_par_en, tx_par_bit, tx_two_stop, tx_stop_idx;
   logic                  tx_line;
   logic                  tx_frame_end;

   assign tx_frame_end = (tx_state == TX_STOP) && (tx_bcnt == DIV_LAST) &&
                         (tx_stop_idx || !tx_two_stop);
   // A new frame starts from IDLE, or straight out of the last stop bit.
   assign tx_pop = (tx_cnt != '0) && ((tx_state == TX_IDLE) || tx_frame_end);

   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         tx_state    <= TX_IDLE;
         tx_bcnt     <= '0;
         tx_bit      <= '0;
         tx_shift    <= '0;
         tx_par_en   <= 1'b0;
         tx_par_bit  <= 1'b0;
         tx_two_stop <= 1'b0;
         tx_stop_idx <= 1'b0;
         tx_line     <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: ;
            TX_START: begin
               if (tx_bcnt == DIV_LAST) begin
                  tx_bcnt  <= '0;
                  tx_bit   <= '0;
                  tx_line  <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_bcnt <= tx_bcnt + CNT_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_bcnt == DIV_LAST) begin
                  tx_bcnt <= '0;
                  if (tx_bit == BIT_LAST) begin
                     if (tx_par_en) begin
                        tx_line  <= tx_par_bit;
                        tx_state <= TX_PARITY;
                     end else begin
                        tx_line     <= 1'b1;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= TX_STOP;
                     end
                  end else begin
                     tx_bit   <= tx_bit + BW'(1);
                     tx_shift <= tx_shift >> 1;
                     tx_line  <= tx_shift[1];
                  end
               end else begin
                  tx_bcnt <= tx_bcnt + CNT_W'(1);
               end
            end
            TX_PARITY: begin
               if (tx_bcnt == DIV_LAST) begin
                  tx_bcnt     <= '0;
                  tx_line     <= 1'b1;
                  tx_stop_idx <= 1'b0;
                  tx_state    <= TX_STOP;
               end else begin
                  tx_bcnt <= tx_bcnt + CNT_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_bcnt == DIV_LAST) begin
                  tx_bcnt <= '0;
                  if (tx_frame_end) tx_state    <= TX_IDLE;
                  else              tx_stop_idx <= 1'b1;
               end else begin
                  tx_bcnt <= tx_bcnt + CNT_W'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase

         // Frame start overrides the transitions above; frame settings are
         // captured here so mid-frame changes cannot affect this frame.
         if (tx_pop) begin
            tx_state    <= TX_START;
            tx_bcnt     <= '0;
            tx_line     <= 1'b0;
            tx_shift    <= tx_head;
            tx_par_en   <= (pi_parity_mode == 2'b01) || (pi_parity_mode == 2'b10);
            tx_par_bit  <= (^tx_head) ^ (pi_parity_mode == 2'b10);
            tx_two_stop <= pi_stop_bits;
         end
      end
   end

   assign po_ut_data  = tx_line;
   assign po_tx_busy  = (tx_state != TX_IDLE);
   assign po_tx_state = tx_state;

   // ---------------------------------------------------------------- RX sync
   logic rx_s1, rx_s2, rx_prev;

   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= pi_ur_data;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]         rx_wr, rx_rd;
   logic [CW-1:0]         rx_cnt;
   logic                  rx_push, rx_pop, rx_full;
   logic [DATA_WIDTH-1:0] rx_shift;

   assign rx_full     = (rx_cnt == DEPTH_C);
   assign po_r_valid  = (rx_cnt != '0);
   assign po_r_data   = po_r_valid ? rx_mem[rx_rd] : '0;
   assign rx_pop      = pi_r_ready && po_r_valid;
   assign po_rx_count = rx_cnt;

   always_ff @(posedge pi_clk) begin
      if (rx_push) rx_mem[rx_wr] <= rx_shift;
   end

   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         rx_wr  <= '0;
         rx_rd  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + AW'(1);
         if (rx_pop)  rx_rd <= rx_rd + AW'(1);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
   end

   // ---------------------------------------------------------------- RX FSM
   rx_state_t        rx_state;
   logic [CNT_W-1:0] rx_bcnt;
   logic [BW-1:0]    rx_bit;
   logic             rx_par_en, rx_par_odd;
   logic             rx_sample, rx_stop_done;
   logic             parity_set, frame_set, overrun_set;

   assign rx_sample    = (rx_bcnt == DIV_LAST);
   assign rx_stop_done = (rx_state == RX_STOP) && rx_sample;
   assign rx_push      = rx_stop_done && !rx_full;
   assign overrun_set  = rx_stop_done && rx_full;
   assign frame_set    = rx_stop_done && !rx_s2;
   assign parity_set   = (rx_state == RX_PARITY) && rx_sample &&
                         (rx_s2 != ((^rx_shift) ^ rx_par_odd));

   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         rx_state   <= RX_IDLE;
         rx_bcnt    <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
      end else begin
         case (rx_state)
            // Arming needs a high-to-low transition of the synchronized line,
            // so after a frame error with the line held low nothing restarts
            // until the line has been seen high again.
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state   <= RX_START_CHK;
                  rx_bcnt    <= '0;
                  rx_par_en  <= (pi_parity_mode == 2'b01) || (pi_parity_mode == 2'b10);
                  rx_par_odd <= (pi_parity_mode == 2'b10);
               end
            end
            RX_START_CHK: begin
               if (rx_bcnt == HALF_LAST) begin
                  rx_bcnt  <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_bcnt <= rx_bcnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_sample) begin
                  rx_bcnt  <= '0;
                  rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
                  if (rx_bit == BIT_LAST) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                  else                    rx_bit   <= rx_bit + BW'(1);
               end else begin
                  rx_bcnt <= rx_bcnt + CNT_W'(1);
               end
            end
            RX_PARITY: begin
               if (rx_sample) begin
                  rx_bcnt  <= '0;
                  rx_state <= RX_STOP;
               end else begin
                  rx_bcnt <= rx_bcnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_sample) begin
                  rx_bcnt  <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_bcnt <= rx_bcnt + CNT_W'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign po_rx_state = rx_state;

   // ---------------------------------------------------------------- errors
   // Clear first, then set, so a new error in the clear cycle survives.
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         po_parity_err  <= 1'b0;
         po_frame_err   <= 1'b0;
         po_overrun_err <= 1'b0;
      end else begin
         if (pi_err_clr) begin
            po_parity_err  <= 1'b0;
            po_frame_err   <= 1'b0;
            po_overrun_err <= 1'b0;
         end
         if (parity_set)  po_parity_err  <= 1'b1;
         if (frame_set)   po_frame_err   <= 1'b1;
         if (overrun_set) po_overrun_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
module tb_uart_fifo_core;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int DIV   = 10000000 / 115200;

   // ------------------------------------------------------------ clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, stop_bits, t_valid, t_ready, ut_data, ur_line;
   logic [1:0]   parity_mode;
   logic [W-1:0] t_data, r_data;
   logic         r_valid, r_ready, busy, par_err, frm_err, ovr_err, err_clr;
   logic [4:0]   tx_count, rx_count;
   logic [2:0]   tx_state_dbg, rx_state_dbg;
   logic         loop_en, tb_rx;

   assign ur_line = loop_en ? ut_data : tb_rx;

   uart_fifo_core dut (
      .pi_clk(clk), .pi_rst(rst), .pi_stop_bits(stop_bits), .pi_parity_mode(parity_mode),
      .pi_t_data(t_data), .pi_t_valid(t_valid), .po_t_ready(t_ready), .po_ut_data(ut_data),
      .pi_ur_data(ur_line), .po_r_data(r_data), .po_r_valid(r_valid), .pi_r_ready(r_ready),
      .po_tx_count(tx_count), .po_rx_count(rx_count), .po_tx_busy(busy),
      .po_parity_err(par_err), .po_frame_err(frm_err), .po_overrun_err(ovr_err),
      .pi_err_clr(err_clr), .po_tx_state(tx_state_dbg), .po_rx_state(rx_state_dbg)
   );

   // ------------------------------------------------------------ scoreboard
   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------ driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reference frame: start 0, data LSB first, parity chosen so the ones
   // count (data + parity) is even/odd, then the stop bits.
   task automatic build_frame(input logic [W-1:0] d, input logic [1:0] pm, input logic sb,
                              output logic [15:0] bits, output int n);
      int ones;
      ones = 0;
      bits = '1;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < W; i++) begin
         bits[n] = d[i];
         if (d[i]) ones++;
         n++;
      end
      if (pm == 2'b01) begin bits[n] = (ones % 2 == 1); n++; end
      else if (pm == 2'b10) begin bits[n] = (ones % 2 == 0); n++; end
      bits[n] = 1'b1; n++;
      if (sb) begin bits[n] = 1'b1; n++; end
   endtask

   // Push one byte into an idle transmitter and check every line bit at its
   // first and last cycle. Optionally disturbs the frame settings mid-frame.
   task automatic tx_frame(input logic [W-1:0] d, input logic [1:0] pm, input logic sb,
                           input bit scramble);
      logic [15:0] bits;
      int n;
      build_frame(d, pm, sb, bits, n);
      parity_mode = pm;
      stop_bits   = sb;
      t_data      = d;
      t_valid     = 1'b1;
      check("tx_idle_line", ut_data, 1);
      step();
      t_valid = 1'b0;
      check("tx_n_plus_1", ut_data, 1);
      step();
      for (int k = 0; k < n; k++) begin
         check($sformatf("tx_bit%0d_first", k), ut_data, bits[k]);
         if (k == 0) check("tx_busy", busy, 1);
         steps(DIV - 1);
         check($sformatf("tx_bit%0d_last", k), ut_data, bits[k]);
         if (k == 0 && scramble) begin
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
         end
         step();
      end
      check("tx_end_busy", busy, 0);
      check("tx_end_line", ut_data, 1);
   endtask

   task automatic drive_rx(input logic [15:0] bits, input int n);
      for (int k = 0; k < n; k++) begin
         tb_rx = bits[k];
         steps(DIV);
      end
      tb_rx = 1'b1;
   endtask

   task automatic wait_rx(input int bound);
      int t;
      t = 0;
      while (!r_valid && t < bound) begin
         step();
         t++;
      end
      check("rx_arrival", r_valid, 1);
   endtask

   task automatic pop_check(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check(tag, r_data, e);
      end
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [15:0] bits;
      int n, t;
      logic [W-1:0] d;
      logic [1:0] pm;
      logic sb;

      rst = 1'b1; stop_bits = 1'b0; parity_mode = 2'b00; t_data = '0; t_valid = 1'b0;
      r_ready = 1'b0; err_clr = 1'b0; loop_en = 1'b0; tb_rx = 1'b1;
      steps(3);
      check("rst_ut_data", ut_data, 1);
      check("rst_t_ready", t_ready, 1);
      check("rst_r_valid", r_valid, 0);
      check("rst_tx_count", tx_count, 0);
      check("rst_rx_count", rx_count, 0);
      check("rst_busy", busy, 0);
      check("rst_errs", {par_err, frm_err, ovr_err}, 0);
      check("rst_r_data", r_data, 0);
      rst = 1'b0;
      step();

      // Loopback, defaults, 0xA5
      loop_en = 1'b1;
      exp_q.push_back(8'hA5);
      tx_frame(8'hA5, 2'b00, 1'b0, 1'b0);
      wait_rx(200);
      check("a5_errs", {par_err, frm_err, ovr_err}, 0);
      pop_check("a5_data");
      check("a5_rx_count", rx_count, 0);

      // Random loopback frames, settings disturbed mid-frame
      repeat (6) begin
         d  = W'($urandom_range(0, 255));
         pm = 2'($urandom_range(0, 3));
         sb = 1'($urandom_range(0, 1));
         exp_q.push_back(d);
         tx_frame(d, pm, sb, 1'b1);
         wait_rx(200);
         check("rand_errs", {par_err, frm_err, ovr_err}, 0);
         pop_check("rand_data");
      end

      // Even parity, two stop bits, 17 bytes with no reads -> overrun
      parity_mode = 2'b01;
      stop_bits   = 1'b1;
      for (int i = 0; i < 17; i++) begin
         t_data  = W'(i);
         t_valid = 1'b1;
         t = 0;
         while (!t_ready && t < 100) begin step(); t++; end
         step();
         if (i < DEPTH) exp_q.push_back(W'(i));
      end
      t_valid = 1'b0;
      check("txq_count_full", tx_count, 16);
      check("txq_ready_full", t_ready, 0);
      t_data  = 8'h77;
      t_valid = 1'b1;
      step();
      t_valid = 1'b0;
      check("txq_push_when_full", tx_count, 16);
      t = 0;
      while ((busy || tx_count != 0) && t < 25000) begin step(); t++; end
      check("txq_drain", {busy, tx_count}, 0);
      steps(50);
      check("ovr_rx_count", rx_count, 16);
      check("ovr_flag", ovr_err, 1);
      check("ovr_other_errs", {par_err, frm_err}, 0);
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovr_read%0d", i));
      check("ovr_empty_valid", r_valid, 0);
      check("ovr_empty_data", r_data, 0);
      clear_errs();
      check("ovr_cleared", ovr_err, 0);

      // Odd parity, bench-driven 0x3C with a wrong then a right parity bit
      loop_en = 1'b0;
      parity_mode = 2'b10;
      stop_bits = 1'b0;
      steps(5);
      build_frame(8'h3C, 2'b10, 1'b0, bits, n);
      bits[1 + W] = ~bits[1 + W];
      exp_q.push_back(8'h3C);
      drive_rx(bits, n);
      steps(DIV);
      check("par_bad_flag", par_err, 1);
      check("par_bad_frame", frm_err, 0);
      pop_check("par_bad_data");
      clear_errs();
      check("par_cleared", par_err, 0);
      build_frame(8'h3C, 2'b10, 1'b0, bits, n);
      exp_q.push_back(8'h3C);
      drive_rx(bits, n);
      steps(DIV);
      check("par_good_flag", par_err, 0);
      pop_check("par_good_data");

      // Frame error on 0x55 followed by a held-low break, then 0x12
      parity_mode = 2'b00;
      build_frame(8'h55, 2'b00, 1'b0, bits, n);
      bits[n - 1] = 1'b0;
      bits[n] = 1'b0; bits[n + 1] = 1'b0;
      n = n + 2;
      exp_q.push_back(8'h55);
      drive_rx(bits, n);
      steps(DIV);
      check("frm_flag", frm_err, 1);
      check("frm_rx_count", rx_count, 1);
      pop_check("frm_data");
      build_frame(8'h12, 2'b00, 1'b0, bits, n);
      exp_q.push_back(8'h12);
      drive_rx(bits, n);
      steps(DIV);
      check("frm_next_count", rx_count, 1);
      pop_check("frm_next_data");
      check("frm_sticky", frm_err, 1);
      check("frm_no_parity", par_err, 0);
      clear_errs();
      check("frm_cleared", frm_err, 0);

      // Glitch: 20 low cycles
      tb_rx = 1'b0;
      steps(20);
      tb_rx = 1'b1;
      steps(200);
      check("glitch_count", rx_count, 0);
      check("glitch_valid", r_valid, 0);
      check("glitch_errs", {par_err, frm_err, ovr_err}, 0);

      // Reset mid data bit with three bytes queued, loopback on
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         t_data  = W'(8'hC0 + i);
         t_valid = 1'b1;
         step();
      end
      t_valid = 1'b0;
      steps(DIV + DIV / 2);
      check("rst_mid_busy_before", busy, 1);
      rst = 1'b1;
      step();
      check("rst_mid_line", ut_data, 1);
      check("rst_mid_tx_count", tx_count, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", t_ready, 1);
      rst = 1'b0;
      steps(12 * DIV);
      check("rst_mid_rx_count", rx_count, 0);
      check("rst_mid_line_idle", ut_data, 1);
      check("rst_mid_errs", {par_err, frm_err, ovr_err}, 0);

      // ---------------------------------------------------------- report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
